// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter between
// the RX echo path (requester 0) and the ALU result serialiser (requester 1).
module uart_tx_arbiter #(
   parameter int unsigned TIMEOUT = 2000000,
   parameter int unsigned TO_W    = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] data0,
   input  logic       last0,
   input  logic       req1,
   input  logic [7:0] data1,
   input  logic       last1,
   input  logic       tx_done,
   input  logic       clr_err,
   output logic [7:0] d_out,
   output logic       tx_start,
   output logic       ack0,
   output logic       ack1,
   output logic       grant0,
   output logic       grant1,
   output logic       busy,
   output logic       timeout_err
);

   localparam int unsigned BYTE_W = 8;
   localparam logic [TO_W-1:0] WD_MAX = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [BYTE_W-1:0] d_out_q, d_out_d;
   logic              tx_start_q, tx_start_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              grant0_q, grant0_d;
   logic              grant1_q, grant1_d;
   logic              busy_q;
   logic              timeout_err_q, timeout_err_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic              last_latched_q, last_latched_d;
   logic [TO_W-1:0]   wd_q, wd_d;
   logic              tx_done_prev_q;

   logic done_edge_c;
   logic wd_max_c;
   logic req_own_c;
   logic any_req_c;
   logic pick_c;
   logic to_set_c;

   // Shared decode: completion edge, watchdog expiry, owner's request, tie-break
   assign done_edge_c = tx_done & ~tx_done_prev_q;
   assign wd_max_c    = (wd_q == WD_MAX);
   assign req_own_c   = owner_q ? req1 : req0;
   assign any_req_c   = req0 | req1;
   assign pick_c      = (req0 & req1) ? ~last_owner_q : req1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (any_req_c) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (req_own_c) begin
               state_d = S_WAIT;
            end else if (wd_max_c) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            // A completion edge beats a coincident watchdog expiry
            if (done_edge_c) begin
               state_d = last_latched_q ? S_IDLE : S_LOAD;
            end else if (wd_max_c) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      d_out_d        = d_out_q;
      tx_start_d     = 1'b0;
      ack0_d         = 1'b0;
      ack1_d         = 1'b0;
      grant0_d       = grant0_q;
      grant1_d       = grant1_q;
      owner_d        = owner_q;
      last_owner_d   = last_owner_q;
      last_latched_d = last_latched_q;
      wd_d           = wd_q;
      to_set_c       = 1'b0;
      case (state_q)
         S_IDLE: begin
            wd_d = '0;
            if (any_req_c) begin
               owner_d  = pick_c;
               grant0_d = ~pick_c;
               grant1_d = pick_c;
            end
         end
         S_LOAD: begin
            if (req_own_c) begin
               d_out_d        = owner_q ? data1 : data0;
               last_latched_d = owner_q ? last1 : last0;
               ack0_d         = ~owner_q;
               ack1_d         = owner_q;
               tx_start_d     = 1'b1;
               wd_d           = '0;
            end else if (wd_max_c) begin
               to_set_c     = 1'b1;
               last_owner_d = owner_q;
               grant0_d     = 1'b0;
               grant1_d     = 1'b0;
               wd_d         = '0;
            end else begin
               wd_d = wd_q + TO_W'(1);
            end
         end
         S_WAIT: begin
            if (done_edge_c) begin
               wd_d = '0;
               if (last_latched_q) begin
                  last_owner_d = owner_q;
                  grant0_d     = 1'b0;
                  grant1_d     = 1'b0;
               end
            end else if (wd_max_c) begin
               to_set_c     = 1'b1;
               last_owner_d = owner_q;
               grant0_d     = 1'b0;
               grant1_d     = 1'b0;
               wd_d         = '0;
            end else begin
               wd_d = wd_q + TO_W'(1);
            end
         end
         default: begin
            grant0_d = 1'b0;
            grant1_d = 1'b0;
            wd_d     = '0;
         end
      endcase
      // A new abort outranks a same-cycle clear
      timeout_err_d = to_set_c | (timeout_err_q & ~clr_err);
   end

   // last_owner resets to 1 so requester 0 wins the first tie
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_out_q        <= '0;
         tx_start_q     <= 1'b0;
         ack0_q         <= 1'b0;
         ack1_q         <= 1'b0;
         grant0_q       <= 1'b0;
         grant1_q       <= 1'b0;
         busy_q         <= 1'b0;
         timeout_err_q  <= 1'b0;
         owner_q        <= 1'b0;
         last_owner_q   <= 1'b1;
         last_latched_q <= 1'b0;
         wd_q           <= '0;
         tx_done_prev_q <= 1'b0;
      end else begin
         d_out_q        <= d_out_d;
         tx_start_q     <= tx_start_d;
         ack0_q         <= ack0_d;
         ack1_q         <= ack1_d;
         grant0_q       <= grant0_d;
         grant1_q       <= grant1_d;
         busy_q         <= (state_d != S_IDLE);
         timeout_err_q  <= timeout_err_d;
         owner_q        <= owner_d;
         last_owner_q   <= last_owner_d;
         last_latched_q <= last_latched_d;
         wd_q           <= wd_d;
         tx_done_prev_q <= tx_done;
      end
   end

   assign d_out       = d_out_q;
   assign tx_start    = tx_start_q;
   assign ack0        = ack0_q;
   assign ack1        = ack1_q;
   assign grant0      = grant0_q;
   assign grant1      = grant1_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule
